// File: rtl/warp_arbiter.sv
// Round-robin warp scheduler: time-multiplexes one core datapath among NUM_WARPS contexts,
// switching on yield, RET or quantum expiry at an instruction boundary.
module warp_arbiter #(
  parameter int unsigned NUM_WARPS = 2,
  parameter int unsigned QUANTUM   = 16,
  localparam int unsigned WB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 yield,
  input  logic [NUM_WARPS-1:0] resume,
  input  logic                 ret,
  input  logic                 pc_update_valid,
  input  logic [7:0]           pc_update,
  output logic [WB-1:0]        active_warp,
  output logic                 active_valid,
  output logic [7:0]           current_pc,
  output logic [NUM_WARPS-1:0] done_mask,
  output logic                 block_done
);

  localparam int unsigned CW = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {StIdle, StSelect, StRun, StDone} state_e;

  state_e                        state_q, state_d;
  logic [NUM_WARPS-1:0][7:0]     pc_q, pc_d;
  logic [NUM_WARPS-1:0]          done_q, done_d;
  logic [NUM_WARPS-1:0]          stall_q, stall_d;
  logic [WB-1:0]                 active_q, active_d;
  logic [WB-1:0]                 last_q, last_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                 cnt_inc;
  logic                          found;
  logic [WB-1:0]                 winner;
  int unsigned                   idx;

  // Round-robin search starting just after the last granted warp.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
      idx = (32'(last_q) + k) % NUM_WARPS;
      if (!found && !done_q[idx] && !stall_q[idx]) begin
        found  = 1'b1;
        winner = WB'(idx);
      end
    end
  end

  assign cnt_inc = (cnt_q == CW'(QUANTUM)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    done_d   = done_q;
    stall_d  = stall_q;
    active_d = active_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          done_d  = '0;
          stall_d = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (&done_q) begin
          state_d = StDone;
        end else if (found) begin
          active_d = winner;
          last_d   = winner;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // RET wins outright: no PC write, no stall.
        if (ret) begin
          done_d[active_q] = 1'b1;
          state_d          = StSelect;
        end else begin
          if (pc_update_valid) pc_d[active_q] = pc_update;
          if (yield) begin
            stall_d[active_q] = 1'b1;
            state_d           = StSelect;
          end else if (pc_update_valid && cnt_inc == CW'(QUANTUM)) begin
            state_d = StSelect;
          end
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A memory response always beats a same-cycle stall request.
    stall_d = stall_d & ~resume;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      done_q   <= '0;
      stall_q  <= '0;
      active_q <= '0;
      last_q   <= WB'(NUM_WARPS - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
      active_q <= active_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active_warp  = active_q;
  assign active_valid = (state_q == StRun);
  assign current_pc   = pc_q[active_q];
  assign done_mask    = done_q;
  assign block_done   = (state_q == StDone);

endmodule
